// File: rtl/usbdev_pin_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module : usbdev_pin_seq_pkg
// Brief  : Shared types and helpers for the USB PHY pin-override sequencer.
//          Provides the line-symbol and FSM-state enums, the override pin
//          bundle, and the symbol-to-pin decode used by the sequencer.
// Rev    : 1.0  initial release
// ============================================================================
package usbdev_pin_seq_pkg;

  typedef enum logic [1:0] {
    SYM_SE0 = 2'd0,
    SYM_J   = 2'd1,
    SYM_K   = 2'd2,
    SYM_HIZ = 2'd3
  } usb_line_sym_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_DRIVE   = 2'd2,
    ST_RELEASE = 2'd3
  } usbdev_pin_seq_state_e;

  // Override pin values presented to the IO mux.
  typedef struct packed {
    logic oe;
    logic d;
    logic dp;
    logic dn;
    logic se0;
  } pin_drv_t;

  localparam pin_drv_t c_pins_off = '0;

  // Line symbol to override pin values. HIZ releases oe and parks all values low.
  function automatic pin_drv_t sym_to_pins(input usb_line_sym_e sym);
    pin_drv_t p;
    p = c_pins_off;
    case (sym)
      SYM_SE0: begin p.oe = 1'b1; p.se0 = 1'b1; end
      SYM_J:   begin p.oe = 1'b1; p.dp = 1'b1; p.d = 1'b1; end
      SYM_K:   begin p.oe = 1'b1; p.dn = 1'b1; end
      default: p = c_pins_off;
    endcase
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/usbdev_pin_seq_if.sv
`default_nettype none
// ============================================================================
// Module : usbdev_pin_seq_if
// Brief  : Control/config and pin-drive bundle of the pin-override sequencer.
//          master: CSR/engine side (drives start/abort/config, eng_tx_oe_i).
//          slave : the sequencer (drives hold, override pins and status).
// Rev    : 1.0  initial release
// ============================================================================
interface usbdev_pin_seq_if #(
  parameter int NUM_STEPS = 4,
  parameter int CNT_W     = 16
);
  localparam int NS_W = $clog2(NUM_STEPS + 1);

  logic                       start_i;
  logic                       abort_i;
  logic [NS_W-1:0]            num_steps_i;
  logic [2*NUM_STEPS-1:0]     step_sym_i;
  logic [CNT_W*NUM_STEPS-1:0] step_len_i;
  logic                       eng_tx_oe_i;
  logic                       eng_hold_o;
  logic                       drv_en_o;
  logic                       drv_oe_o;
  logic                       drv_d_o;
  logic                       drv_dp_o;
  logic                       drv_dn_o;
  logic                       drv_se0_o;
  logic                       busy_o;
  logic                       done_o;
  logic                       aborted_o;

  modport master (
    output start_i, abort_i, num_steps_i, step_sym_i, step_len_i, eng_tx_oe_i,
    input  eng_hold_o, drv_en_o, drv_oe_o, drv_d_o, drv_dp_o, drv_dn_o,
           drv_se0_o, busy_o, done_o, aborted_o
  );

  modport slave (
    input  start_i, abort_i, num_steps_i, step_sym_i, step_len_i, eng_tx_oe_i,
    output eng_hold_o, drv_en_o, drv_oe_o, drv_d_o, drv_dp_o, drv_dn_o,
           drv_se0_o, busy_o, done_o, aborted_o
  );
endinterface
`default_nettype wire

// File: rtl/usbdev_pin_seq_timer.sv
`default_nettype none
// ============================================================================
// Module : usbdev_pin_seq_timer
// Brief  : Loadable down-counter shared by the guard window and the per-step
//          duration. expire_o is high while the current count is the final
//          one, so the owner acts on the same cycle it applies the last tick.
// Ports  : clk_i, rst_i      clock / sync active-high reset
//          load_i, load_val_i load a new count (priority over en_i)
//          en_i              decrement by one
//          expire_o          current count <= 1
// Rev    : 1.0  initial release
// ============================================================================
module usbdev_pin_seq_timer #(
  parameter int CNT_W = 16
) (
  input  wire logic             clk_i,
  input  wire logic             rst_i,
  input  wire logic             load_i,
  input  wire logic [CNT_W-1:0] load_val_i,
  input  wire logic             en_i,
  output logic                  expire_o
);
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count <= '0;
    end else if (load_i) begin
      r_count <= load_val_i;
    end else if (en_i && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  // A count of 0 is also treated as expired so the owner can never stall.
  assign expire_o = (r_count <= CNT_W'(1));
endmodule
`default_nettype wire

// File: rtl/usbdev_pin_seq.sv
`default_nettype none
// ============================================================================
// Module : usbdev_pin_seq
// Brief  : USB PHY pin-override sequencer. Takes the bus from the engine via a
//          hold/guard handshake, plays up to NUM_STEPS line symbols each held
//          for an exact cycle count, then hands the bus back through a
//          one-cycle RELEASE. All outputs are registered.
// Ports  : clk_i, rst_i  clock / sync active-high reset
//          bus (slave)   start/abort/config + engine tx_oe in;
//                        eng_hold, override pins, busy/done/aborted out
// Rev    : 1.0  initial release
// ============================================================================
module usbdev_pin_seq
  import usbdev_pin_seq_pkg::*;
#(
  parameter int NUM_STEPS    = 4,
  parameter int CNT_W        = 16,
  parameter int GUARD_CYCLES = 4
) (
  input wire logic         clk_i,
  input wire logic         rst_i,
  usbdev_pin_seq_if.slave  bus
);
  localparam int NS_W   = $clog2(NUM_STEPS + 1);
  localparam int STEP_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam logic [CNT_W-1:0] c_guard = CNT_W'(GUARD_CYCLES);

  usbdev_pin_seq_state_e      r_state, w_state_n;
  logic [STEP_W-1:0]          r_step, w_step_n, w_step_inc, r_last;
  logic [2*NUM_STEPS-1:0]     r_sym;
  logic [CNT_W*NUM_STEPS-1:0] r_len;
  logic                       r_abort_pend, w_abort_pend_n;
  logic                       w_latch;
  logic                       w_t_load, w_t_en, w_t_expire;
  logic [CNT_W-1:0]           w_t_val, w_len_first, w_len_next;
  logic [NS_W-1:0]            w_nsteps_clamped;
  logic [STEP_W-1:0]          w_last_in;

  logic     r_hold, r_en, r_busy, r_done, r_aborted;
  pin_drv_t r_pins;
  logic     w_hold_n, w_en_n, w_busy_n, w_done_n, w_aborted_n;
  pin_drv_t w_pins_n;

  usbdev_pin_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (w_t_load),
    .load_val_i (w_t_val),
    .en_i       (w_t_en),
    .expire_o   (w_t_expire)
  );

  assign w_nsteps_clamped = (bus.num_steps_i > NS_W'(NUM_STEPS)) ? NS_W'(NUM_STEPS)
                                                                 : bus.num_steps_i;
  assign w_last_in  = STEP_W'(w_nsteps_clamped - NS_W'(1));
  assign w_step_inc = r_step + STEP_W'(1);

  // A programmed length of 0 still shows the symbol for one cycle.
  always_comb begin
    w_len_first = r_len[0 +: CNT_W];
    w_len_next  = r_len[CNT_W*w_step_inc +: CNT_W];
    if (w_len_first == '0) w_len_first = CNT_W'(1);
    if (w_len_next  == '0) w_len_next  = CNT_W'(1);
  end

  // State and shadow registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_step       <= '0;
      r_last       <= '0;
      r_sym        <= '0;
      r_len        <= '0;
      r_abort_pend <= 1'b0;
      r_hold       <= 1'b0;
      r_en         <= 1'b0;
      r_pins       <= c_pins_off;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_step       <= w_step_n;
      r_abort_pend <= w_abort_pend_n;
      if (w_latch) begin
        r_last <= w_last_in;
        r_sym  <= bus.step_sym_i;
        r_len  <= bus.step_len_i;
      end
      r_hold    <= w_hold_n;
      r_en      <= w_en_n;
      r_pins    <= w_pins_n;
      r_busy    <= w_busy_n;
      r_done    <= w_done_n;
      r_aborted <= w_aborted_n;
    end
  end

  // Next-state and timer control.
  always_comb begin
    w_state_n      = r_state;
    w_step_n       = r_step;
    w_abort_pend_n = r_abort_pend;
    w_latch        = 1'b0;
    w_t_load       = 1'b0;
    w_t_val        = c_guard;
    w_t_en         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_abort_pend_n = 1'b0;
        // Abort in the same cycle as start cancels the start outright.
        if (bus.start_i && !bus.abort_i) begin
          w_latch = 1'b1;
          if (bus.num_steps_i != '0) begin
            w_state_n = ST_HOLD;
            w_t_load  = 1'b1;
            w_t_val   = c_guard;
          end
        end
      end
      ST_HOLD: begin
        if (bus.abort_i) begin
          w_state_n = ST_IDLE;
        end else if (bus.eng_tx_oe_i) begin
          // Engine still talking: restart the quiet window.
          w_t_load = 1'b1;
          w_t_val  = c_guard;
        end else begin
          w_t_en = 1'b1;
          if (w_t_expire) begin
            w_state_n = ST_DRIVE;
            w_step_n  = '0;
            w_t_load  = 1'b1;
            w_t_val   = w_len_first;
          end
        end
      end
      ST_DRIVE: begin
        if (bus.abort_i) begin
          w_state_n      = ST_RELEASE;
          w_abort_pend_n = 1'b1;
        end else begin
          w_t_en = 1'b1;
          if (w_t_expire) begin
            if (r_step == r_last) begin
              w_state_n = ST_RELEASE;
            end else begin
              w_step_n = w_step_inc;
              w_t_load = 1'b1;
              w_t_val  = w_len_next;
            end
          end
        end
      end
      default: begin
        w_state_n      = ST_IDLE;
        w_abort_pend_n = 1'b0;
      end
    endcase
  end

  // Output decode from the state being entered, registered above.
  always_comb begin
    w_busy_n    = (w_state_n != ST_IDLE);
    w_hold_n    = (w_state_n != ST_IDLE);
    w_en_n      = (w_state_n == ST_DRIVE) || (w_state_n == ST_RELEASE);
    w_pins_n    = c_pins_off;
    if (w_state_n == ST_DRIVE) begin
      w_pins_n = sym_to_pins(usb_line_sym_e'(r_sym[2*w_step_n +: 2]));
    end
    w_done_n    = 1'b0;
    w_aborted_n = 1'b0;
    case (r_state)
      ST_IDLE:    w_done_n    = bus.start_i && !bus.abort_i && (bus.num_steps_i == '0);
      ST_HOLD:    w_aborted_n = bus.abort_i;
      ST_RELEASE: begin
        w_done_n    = !r_abort_pend;
        w_aborted_n = r_abort_pend;
      end
      default: ;
    endcase
  end

  assign bus.eng_hold_o = r_hold;
  assign bus.drv_en_o   = r_en;
  assign bus.drv_oe_o   = r_pins.oe;
  assign bus.drv_d_o    = r_pins.d;
  assign bus.drv_dp_o   = r_pins.dp;
  assign bus.drv_dn_o   = r_pins.dn;
  assign bus.drv_se0_o  = r_pins.se0;
  assign bus.busy_o     = r_busy;
  assign bus.done_o     = r_done;
  assign bus.aborted_o  = r_aborted;
endmodule
`default_nettype wire

// File: tb/tb_usbdev_pin_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_usbdev_pin_seq
// Brief  : Directed bench for usbdev_pin_seq. Cycle 0 is the cycle in which
//          start_i is presented; outputs are sampled 1 time unit after each
//          rising edge and compared against hand-built per-cycle vectors
//          {hold, en, oe, d, dp, dn, se0, busy, done, aborted}.
// Rev    : 1.0  initial release
// ============================================================================
module tb_usbdev_pin_seq;
  localparam int NS = 4;
  localparam int CW = 16;
  localparam int GC = 4;

  // Pin patterns {oe, d, dp, dn, se0}
  localparam logic [4:0] P_SE0 = 5'b10001;
  localparam logic [4:0] P_J   = 5'b11100;
  localparam logic [4:0] P_K   = 5'b10010;
  localparam logic [4:0] P_OFF = 5'b00000;
  // Full observation vectors {hold, en, pins[4:0], busy, done, aborted}
  localparam logic [9:0] V_IDLE = 10'b00_00000_000;
  localparam logic [9:0] V_HOLD = 10'b10_00000_100;
  localparam logic [9:0] V_REL  = 10'b11_00000_100;
  localparam logic [9:0] V_DONE = 10'b00_00000_010;
  localparam logic [9:0] V_ABT  = 10'b00_00000_001;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  usbdev_pin_seq_if #(.NUM_STEPS(NS), .CNT_W(CW)) bus ();

  usbdev_pin_seq #(.NUM_STEPS(NS), .CNT_W(CW), .GUARD_CYCLES(GC)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  function automatic logic [9:0] v_drv(input logic [4:0] p);
    return {2'b11, p, 3'b100};
  endfunction

  function automatic logic [9:0] obs();
    return {bus.eng_hold_o, bus.drv_en_o, bus.drv_oe_o, bus.drv_d_o, bus.drv_dp_o,
            bus.drv_dn_o, bus.drv_se0_o, bus.busy_o, bus.done_o, bus.aborted_o};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents start_i for one cycle; returns at cycle 1.
  task automatic start_seq(input int n, input logic [7:0] sym, input logic [63:0] len);
    bus.num_steps_i = 3'(n);
    bus.step_sym_i  = sym;
    bus.step_len_i  = len;
    bus.start_i     = 1'b1;
    tick();
    bus.start_i     = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] o;
    rst = 1'b1;
    tick();
    tick();
    o = obs(); total++;
    if (o !== V_IDLE) begin bad++; $display("FAIL reset_held: got %b want %b", o, V_IDLE); end
    rst = 1'b0;
    tick();
    o = obs(); total++;
    if (o !== V_IDLE) begin bad++; $display("FAIL reset_released: got %b want %b", o, V_IDLE); end
  endtask

  // One SE0 step of 10 cycles.
  task automatic test_se0();
    logic [9:0] o, e;
    start_seq(1, 8'h00, {48'h0, 16'd10});
    for (int c = 1; c <= 17; c++) begin
      e = (c <= 4) ? V_HOLD : (c <= 14) ? v_drv(P_SE0) : (c == 15) ? V_REL :
          (c == 16) ? V_DONE : V_IDLE;
      o = obs(); total++;
      if (o !== e) begin bad++; $display("FAIL se0 cycle %0d: got %b want %b", c, o, e); end
      tick();
    end
  endtask

  // K for 3 cycles then J with length 0 (one cycle).
  task automatic test_kj();
    logic [9:0] o, e;
    start_seq(2, 8'h06, {32'h0, 16'd0, 16'd3});
    for (int c = 1; c <= 11; c++) begin
      e = (c <= 4) ? V_HOLD : (c <= 7) ? v_drv(P_K) : (c == 8) ? v_drv(P_J) :
          (c == 9) ? V_REL : (c == 10) ? V_DONE : V_IDLE;
      o = obs(); total++;
      if (o !== e) begin bad++; $display("FAIL kj cycle %0d: got %b want %b", c, o, e); end
      tick();
    end
  endtask

  // Engine tx_oe high in cycles 1-6 and cycle 8 restarts the guard window.
  task automatic test_guard();
    logic [9:0] o, e;
    start_seq(1, 8'h01, {48'h0, 16'd2});
    for (int c = 1; c <= 17; c++) begin
      e = (c <= 12) ? V_HOLD : (c <= 14) ? v_drv(P_J) : (c == 15) ? V_REL :
          (c == 16) ? V_DONE : V_IDLE;
      o = obs(); total++;
      if (o !== e) begin bad++; $display("FAIL guard cycle %0d: got %b want %b", c, o, e); end
      bus.eng_tx_oe_i = ((c >= 1) && (c <= 6)) || (c == 8);
      tick();
    end
    bus.eng_tx_oe_i = 1'b0;
  endtask

  task automatic test_abort();
    logic [9:0] o, e;
    // Steps J/1, SE0/100, K/1, J/1; abort during cycle 8 (third SE0 cycle).
    start_seq(4, 8'h61, {16'd1, 16'd1, 16'd100, 16'd1});
    for (int c = 1; c <= 14; c++) begin
      e = (c <= 4) ? V_HOLD : (c == 5) ? v_drv(P_J) : (c <= 8) ? v_drv(P_SE0) :
          (c == 9) ? V_REL : (c == 10) ? V_ABT : V_IDLE;
      o = obs(); total++;
      if (o !== e) begin bad++; $display("FAIL abort_drive cycle %0d: got %b want %b", c, o, e); end
      bus.abort_i = (c == 8);
      tick();
    end
    bus.abort_i = 1'b0;
    // Abort during HOLD (cycle 2): back to idle, pins never taken.
    start_seq(1, 8'h00, {48'h0, 16'd5});
    for (int c = 1; c <= 12; c++) begin
      e = (c <= 2) ? V_HOLD : (c == 3) ? V_ABT : V_IDLE;
      o = obs(); total++;
      if (o !== e) begin bad++; $display("FAIL abort_hold cycle %0d: got %b want %b", c, o, e); end
      bus.abort_i = (c == 2);
      tick();
    end
    bus.abort_i = 1'b0;
  endtask

  task automatic test_num_steps();
    logic [9:0] o, e;
    start_seq(0, 8'h00, 64'h0);
    for (int c = 1; c <= 3; c++) begin
      e = (c == 1) ? V_DONE : V_IDLE;
      o = obs(); total++;
      if (o !== e) begin bad++; $display("FAIL zero_steps cycle %0d: got %b want %b", c, o, e); end
      tick();
    end
    // 7 requested, clamps to 4: SE0, J, K, HIZ, each 2 cycles.
    start_seq(7, 8'hE4, 64'h0002_0002_0002_0002);
    for (int c = 1; c <= 15; c++) begin
      e = (c <= 4) ? V_HOLD : (c <= 6) ? v_drv(P_SE0) : (c <= 8) ? v_drv(P_J) :
          (c <= 10) ? v_drv(P_K) : (c <= 12) ? v_drv(P_OFF) : (c == 13) ? V_REL :
          (c == 14) ? V_DONE : V_IDLE;
      o = obs(); total++;
      if (o !== e) begin bad++; $display("FAIL clamp_steps cycle %0d: got %b want %b", c, o, e); end
      tick();
    end
  endtask

  // Reset during the third DRIVE cycle drops everything on the next edge.
  task automatic test_reset_mid();
    logic [9:0] o, e;
    start_seq(1, 8'h00, {48'h0, 16'd10});
    for (int c = 1; c <= 20; c++) begin
      e = (c <= 4) ? V_HOLD : (c <= 7) ? v_drv(P_SE0) : V_IDLE;
      o = obs(); total++;
      if (o !== e) begin bad++; $display("FAIL reset_mid cycle %0d: got %b want %b", c, o, e); end
      rst = (c == 7);
      tick();
    end
    rst = 1'b0;
  endtask

  task automatic test_start_abort();
    logic [9:0] o;
    bus.abort_i = 1'b1;
    start_seq(1, 8'h00, {48'h0, 16'd2});
    bus.abort_i = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      o = obs(); total++;
      if (o !== V_IDLE) begin bad++; $display("FAIL start_abort cycle %0d: got %b want %b", c, o, V_IDLE); end
      tick();
    end
  endtask

  // A second start in HOLD with a different config must be ignored.
  task automatic test_start_busy();
    logic [9:0] o, e;
    start_seq(1, 8'h02, {48'h0, 16'd3});
    for (int c = 1; c <= 11; c++) begin
      e = (c <= 4) ? V_HOLD : (c <= 7) ? v_drv(P_K) : (c == 8) ? V_REL :
          (c == 9) ? V_DONE : V_IDLE;
      o = obs(); total++;
      if (o !== e) begin bad++; $display("FAIL start_busy cycle %0d: got %b want %b", c, o, e); end
      if (c == 2) begin
        bus.num_steps_i = 3'd1;
        bus.step_sym_i  = 8'h01;
        bus.step_len_i  = {48'h0, 16'd8};
      end
      bus.start_i = (c == 2);
      tick();
    end
    bus.start_i = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    bus.start_i     = 1'b0;
    bus.abort_i     = 1'b0;
    bus.num_steps_i = '0;
    bus.step_sym_i  = '0;
    bus.step_len_i  = '0;
    bus.eng_tx_oe_i = 1'b0;
    test_reset();
    test_se0();
    test_kj();
    test_guard();
    test_abort();
    test_num_steps();
    test_reset_mid();
    test_start_abort();
    test_start_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
`default_nettype wire
